// File: rtl/axi_pipeline_pkg.sv
// Shared types and helpers for the registered valid/ready pipeline.
// Holds the skid-slice state encoding and a width helper.
package axi_pipeline_pkg;

    typedef enum logic [1:0] {
        HSP_EMPTY = 2'd0,
        HSP_ONE   = 2'd1,
        HSP_FULL  = 2'd2
    } hsp_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int hsp_clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/hs_skid_slice.sv
// One fully registered valid/ready stage: main + skid register.
// Ready is a flop, so neither direction has a combinational path.
module hs_skid_slice
    import axi_pipeline_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    hsp_state_e   state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         ready_q, ready_d;
    logic         in_xfer;
    logic         out_xfer;

    assign out_valid = (state_q != HSP_EMPTY);
    assign out_data  = main_q;
    assign in_ready  = ready_q;
    assign in_xfer   = in_valid && ready_q;
    assign out_xfer  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            HSP_EMPTY: begin
                if (in_xfer) begin
                    state_d = HSP_ONE;
                    main_d  = in_data;
                end
            end
            HSP_ONE: begin
                if (in_xfer && !out_xfer) begin
                    state_d = HSP_FULL;
                    skid_d  = in_data;
                end else if (!in_xfer && out_xfer) begin
                    state_d = HSP_EMPTY;
                end else if (in_xfer && out_xfer) begin
                    main_d = in_data;
                end
            end
            HSP_FULL: begin
                if (out_xfer) begin
                    state_d = HSP_ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = HSP_EMPTY;
            end
        endcase
        // Look ahead one state so the flop never over-admits.
        ready_d = (state_d != HSP_FULL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HSP_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/handshake_pipeline.sv
// D-stage registered valid/ready pipeline; D=0 is a plain wire bypass.
// Define HSP_OCCUPANCY_EN to add the occupancy port and beat counter.
module handshake_pipeline
    import axi_pipeline_pkg::*;
#(
    parameter int W = 32,
    parameter int D = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
`ifdef HSP_OCCUPANCY_EN
    ,
    output logic [hsp_clog2(2*D+1)-1:0] occupancy
`endif
);

    if (D == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = ^{clk, rst};
        assign m_valid = s_valid;
        assign m_data  = s_data;
        assign s_ready = m_ready;
    end else begin : g_chain
        logic         valid_c [0:D];
        logic         ready_c [0:D];
        logic [W-1:0] data_c  [0:D];

        assign valid_c[0] = s_valid;
        assign data_c[0]  = s_data;
        assign s_ready    = ready_c[0];
        assign m_valid    = valid_c[D];
        assign m_data     = data_c[D];
        assign ready_c[D] = m_ready;

        for (genvar g = 0; g < D; g++) begin : g_slice
            hs_skid_slice #(
                .W(W)
            ) u_slice (
                .clk      (clk),
                .rst      (rst),
                .in_valid (valid_c[g]),
                .in_ready (ready_c[g]),
                .in_data  (data_c[g]),
                .out_valid(valid_c[g+1]),
                .out_ready(ready_c[g+1]),
                .out_data (data_c[g+1])
            );
        end
    end

`ifdef HSP_OCCUPANCY_EN
    localparam int OW = hsp_clog2(2*D+1);

    if (D == 0) begin : g_occ_zero
        assign occupancy = '0;
    end else begin : g_occ
        logic [OW-1:0] occ_q, occ_d;
        logic          s_xfer;
        logic          m_xfer;

        assign s_xfer    = s_valid && s_ready;
        assign m_xfer    = m_valid && m_ready;
        assign occupancy = occ_q;

        always_comb begin
            occ_d = occ_q;
            if (s_xfer && !m_xfer) begin
                occ_d = occ_q + OW'(1);
            end else if (!s_xfer && m_xfer) begin
                occ_d = occ_q - OW'(1);
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                occ_q <= '0;
            end else begin
                occ_q <= occ_d;
            end
        end
    end
`endif

endmodule
